// File: rtl/serial_pixel_collector.sv
// Reassembles LSB-first digit-serial channel words into full vectors tagged with sof/eol/eof.
// Vector is visible one cycle after its last digit (FWFT FIFO); input cannot stall, so a full FIFO drops words and sets overflow.
module serial_pixel_collector #(
    parameter int IMG_SIZE   = 32,
    parameter int CH         = 64,
    parameter int BW         = 16,
    parameter int DIGIT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      vld_in,
    input  logic [CH-1:0][DIGIT-1:0]  in,
    input  logic                      out_rdy,
    output logic                      out_vld,
    output logic [CH-1:0][BW-1:0]     out,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof,
    output logic                      overflow,
    output logic                      frame_err
);
    localparam int CYCS = BW / DIGIT;
    localparam int CW   = (CYCS > 1) ? $clog2(CYCS) : 1;
    localparam int PW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    logic [CW-1:0]             dcnt_q, dcnt_d;
    logic [CH-1:0][BW-1:0]     asm_q, asm_d;
    logic [PW-1:0]             col_q, col_d, row_q, row_d;
    logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CH-1:0][BW-1:0]     dat_q [FIFO_DEPTH];
    logic [CH-1:0][BW-1:0]     dat_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                      overflow_q, overflow_d;
    logic                      frame_err_q, frame_err_d;

    logic                      word_done, empty, full, pop, push;
    logic                      tag_sof, tag_eol, tag_eof;
    logic [CH-1:0][BW-1:0]     word;
    logic [AW-1:0]             wr_idx, rd_idx;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign pop     = !empty && out_rdy;
    assign word_done = vld_in && (dcnt_q == CW'(CYCS - 1));
    // A pop in the same cycle frees the slot the push will land in.
    assign push    = word_done && (!full || pop);

    assign tag_sof = (row_q == '0) && (col_q == '0);
    assign tag_eol = (col_q == PW'(IMG_SIZE - 1));
    assign tag_eof = tag_eol && (row_q == PW'(IMG_SIZE - 1));

    always_comb begin
        word = asm_q;
        for (int c = 0; c < CH; c++) begin
            word[c][BW-DIGIT +: DIGIT] = in[c];
        end
    end

    always_comb begin
        dcnt_d      = dcnt_q;
        asm_d       = asm_q;
        col_d       = col_q;
        row_d       = row_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dat_d       = dat_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        eof_d       = eof_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;

        if (vld_in) begin
            for (int c = 0; c < CH; c++) begin
                asm_d[c][int'(dcnt_q) * DIGIT +: DIGIT] = in[c];
            end
            dcnt_d = word_done ? '0 : dcnt_q + CW'(1);
        end else if (dcnt_q != '0) begin
            dcnt_d      = '0;
            frame_err_d = 1'b1;
        end

        // Position advances even for dropped words to keep framing aligned.
        if (word_done) begin
            if (tag_eol) begin
                col_d = '0;
                row_d = tag_eof ? '0 : row_q + PW'(1);
            end else begin
                col_d = col_q + PW'(1);
            end
            if (push) begin
                dat_d[wr_idx] = word;
                sof_d[wr_idx] = tag_sof;
                eol_d[wr_idx] = tag_eol;
                eof_d[wr_idx] = tag_eof;
                wr_ptr_d      = wr_ptr_q + (AW+1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end

        if (reset) begin
            dcnt_d      = '0;
            asm_d       = '0;
            col_d       = '0;
            row_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dat_d[i] = '0;
            end
            sof_d       = '0;
            eol_d       = '0;
            eof_d       = '0;
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        dcnt_q      <= dcnt_d;
        asm_q       <= asm_d;
        col_q       <= col_d;
        row_q       <= row_d;
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        dat_q       <= dat_d;
        sof_q       <= sof_d;
        eol_q       <= eol_d;
        eof_q       <= eof_d;
        overflow_q  <= overflow_d;
        frame_err_q <= frame_err_d;
    end

    assign out_vld   = !empty;
    assign out       = dat_q[rd_idx];
    assign out_sof   = sof_q[rd_idx];
    assign out_eol   = eol_q[rd_idx];
    assign out_eof   = eof_q[rd_idx];
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_pixel_collector.sv
// Scoreboard bench for serial_pixel_collector: directed words, expected vectors queued at issue, popped by a monitor.
module tb_serial_pixel_collector;
    localparam int IMG = 32;
    localparam int CH  = 64;
    localparam int BW  = 16;
    localparam int DG  = 4;
    localparam int NPIX = IMG * IMG;

    typedef logic [CH-1:0][BW-1:0] vec_t;
    typedef struct packed {
        vec_t dat;
        logic sof;
        logic eol;
        logic eof;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic vld_in = 1'b0;
    logic [CH-1:0][DG-1:0] in = '0;
    logic out_rdy = 1'b0;
    logic out_vld, out_sof, out_eol, out_eof, overflow, frame_err;
    vec_t out;

    int n_vec = 0;
    int n_bad = 0;
    int pos = 0;
    exp_t sb[$];

    serial_pixel_collector dut (
        .clock(clock), .reset(reset), .vld_in(vld_in), .in(in), .out_rdy(out_rdy),
        .out_vld(out_vld), .out(out), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && out_vld && out_rdy) begin
            exp_t e;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_vector got ch0=%h sof=%b eol=%b eof=%b, required none", out[0], out_sof, out_eol, out_eof);
            end else begin
                e = sb.pop_front();
                if ({out, out_sof, out_eol, out_eof} !== {e.dat, e.sof, e.eol, e.eof}) begin
                    n_bad++;
                    $display("FAIL vector got ch0=%h ch63=%h sof=%b eol=%b eof=%b, required ch0=%h ch63=%h sof=%b eol=%b eof=%b",
                             out[0], out[CH-1], out_sof, out_eol, out_eof,
                             e.dat[0], e.dat[CH-1], e.sof, e.eol, e.eof);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t fill(input logic [BW-1:0] v);
        vec_t w;
        for (int c = 0; c < CH; c++) w[c] = v;
        return w;
    endfunction

    function automatic vec_t pix(input int p);
        vec_t w;
        for (int c = 0; c < CH; c++) w[c] = BW'((p * CH + c) % 65536);
        return w;
    endfunction

    // Expected tags come from the bench's own pixel index.
    task automatic expect_word(input vec_t w, input bit dropped);
        exp_t e;
        e.dat = w;
        e.sof = (pos == 0);
        e.eol = ((pos % IMG) == IMG - 1);
        e.eof = (pos == NPIX - 1);
        if (!dropped) sb.push_back(e);
        pos = (pos + 1) % NPIX;
    endtask

    task automatic send_word(input vec_t w, input bit rdy_last);
        for (int k = 0; k < BW / DG; k++) begin
            vld_in = 1'b1;
            for (int c = 0; c < CH; c++) in[c] = w[c][k*DG +: DG];
            if (rdy_last && k == BW / DG - 1) out_rdy = 1'b1;
            @(posedge clock); #1;
        end
        vld_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vld_in = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        pos = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clock); #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_drain got %0d pending required 0", name, sb.size());
        end
        chk({name, "_idle_vld"}, 32'(out_vld), 0);
    endtask

    initial begin
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_out_zero", 32'(out == '0), 1);
        chk("rst_flags", {29'd0, out_sof, out_eol, out_eof}, 0);

        // Single word F,E,E,B -> 0xBEEF
        out_rdy = 1'b1;
        expect_word(fill(16'hBEEF), 0);
        send_word(fill(16'hBEEF), 0);
        chk("single_latency_vld", 32'(out_vld), 1);
        @(posedge clock); #1;
        chk("single_one_cycle", 32'(out_vld), 0);
        drain("single");

        // Full frame plus the first word of the next frame
        do_reset();
        out_rdy = 1'b1;
        for (int p = 0; p < NPIX; p++) begin
            expect_word(pix(p), 0);
            send_word(pix(p), 0);
        end
        expect_word(fill(16'h0042), 0);
        send_word(fill(16'h0042), 0);
        chk("frame_overflow", 32'(overflow), 0);
        drain("frame");

        // Backpressure: fifth word dropped, position still advances
        do_reset();
        out_rdy = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            expect_word(fill(BW'(v)), v == 5);
            send_word(fill(BW'(v)), 0);
            if (v == 1) chk("bp_vld_after_1", 32'(out_vld), 1);
            if (v == 4) chk("bp_no_ovf_at_4", 32'(overflow), 0);
        end
        chk("bp_overflow", 32'(overflow), 1);
        out_rdy = 1'b1;
        drain("bp");
        for (int v = 0; v < IMG - 5; v++) begin
            expect_word(fill(BW'(100 + v)), 0);
            send_word(fill(BW'(100 + v)), 0);
        end
        drain("bp_row");
        chk("bp_overflow_sticky", 32'(overflow), 1);

        // Full FIFO with a pop in the completing cycle
        do_reset();
        out_rdy = 1'b0;
        for (int v = 11; v <= 14; v++) begin
            expect_word(fill(BW'(v)), 0);
            send_word(fill(BW'(v)), 0);
        end
        expect_word(fill(16'd15), 0);
        send_word(fill(16'd15), 1);
        chk("fullpop_overflow", 32'(overflow), 0);
        drain("fullpop");

        // Mid-word drop then clean word
        do_reset();
        out_rdy = 1'b1;
        vld_in = 1'b1;
        in = {CH{4'h7}};
        @(posedge clock); #1;
        @(posedge clock); #1;
        vld_in = 1'b0;
        @(posedge clock); #1;
        chk("midword_frame_err", 32'(frame_err), 1);
        chk("midword_no_vld", 32'(out_vld), 0);
        expect_word(fill(16'h1234), 0);
        send_word(fill(16'h1234), 0);
        drain("midword");

        // Reset with two buffered vectors and a partial word
        out_rdy = 1'b0;
        send_word(fill(16'h0011), 0);
        send_word(fill(16'h0022), 0);
        chk("prereset_vld", 32'(out_vld), 1);
        vld_in = 1'b1;
        in = {CH{4'h3}};
        @(posedge clock); #1;
        @(posedge clock); #1;
        do_reset();
        chk("midrst_out_vld", 32'(out_vld), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_frame_err", 32'(frame_err), 0);
        out_rdy = 1'b1;
        expect_word(fill(16'hA5A5), 0);
        send_word(fill(16'hA5A5), 0);
        drain("midrst");
        chk("final_frame_err", 32'(frame_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
